afpm_div_iter: RTL and testbench

- Iterative approximate IEEE-754 binary32 divider; the inverse operator of the approximate FP multipliers in the AFPM family.
- Keeps only the top E+A significand bits of each operand; the remaining T bits are truncated.
- Produces quotient significand bits with a restoring shift-subtract loop, one bit per clock.
- Sits beside the multiplier behind a valid/ready handshake, so the core/coprocessor can stall on it.

---
 rtl/afpm_pkg.sv | 39 +++
 rtl/afpm_sig_divider.sv | 55 +++++
 rtl/afpm_div_iter.sv | 138 +++++++++++++
 tb/tb_afpm_div_iter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/afpm_pkg.sv
// Shared AFPM types, float32 constants and operand classification.
// Used by the approximate multipliers and the iterative divider.
package afpm_pkg;

    localparam int FLOAT32_EXP_WIDTH = 8;
    localparam int FLOAT32_SIG_WIDTH = 23;
    localparam int EXP_BIAS = 127;

    localparam logic [31:0] FP_NAN = 32'h7FFF_FFFF;
    localparam logic [FLOAT32_EXP_WIDTH-1:0] FP_INF_EXP = 8'hFF;

    typedef struct packed {
        logic                         sign;
        logic [FLOAT32_EXP_WIDTH-1:0] exp;
        logic [FLOAT32_SIG_WIDTH-1:0] frac;
    } float32_t;

    typedef struct packed {
        logic is_nan;
        logic is_inf;
        logic is_zero;
    } fp_class_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

    // Subnormals classify as zero: the AFPM family flushes them.
    function automatic fp_class_t fp_classify(float32_t f);
        fp_class_t c;
        c.is_nan  = (f.exp == FP_INF_EXP) && (f.frac != '0);
        c.is_inf  = (f.exp == FP_INF_EXP) && (f.frac == '0);
        c.is_zero = (f.exp == '0);
        return c;
    endfunction

endpackage

// File: rtl/afpm_sig_divider.sv
// Restoring shift-subtract significand divider, one quotient bit per clock.
// Produces W+1 bits; bit W is the integer bit of a/b in (0.5, 2).
module afpm_sig_divider
    import afpm_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a_sig,
    input  logic [W-1:0] b_sig,
    output logic         done,
    output logic [W:0]   quotient
);

    localparam int Q  = W + 1;
    localparam int CW = $clog2(Q + 1);

    logic [W:0]    rem;
    logic [W-1:0]  div;
    logic [CW-1:0] count;
    logic          busy;
    logic          q_bit;
    logic [W:0]    diff;

    always_comb begin
        q_bit = (rem >= {1'b0, div});
        diff  = q_bit ? (rem - {1'b0, div}) : rem;
        done  = busy && (count == CW'(Q - 1));
    end

    // diff < div after the restore step, so the shift never drops a set bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem      <= '0;
            div      <= '0;
            count    <= '0;
            busy     <= 1'b0;
            quotient <= '0;
        end else if (start) begin
            rem      <= {1'b0, a_sig};
            div      <= b_sig;
            count    <= '0;
            busy     <= 1'b1;
            quotient <= '0;
        end else if (busy) begin
            rem      <= {diff[W-1:0], 1'b0};
            quotient <= {quotient[W-1:0], q_bit};
            count    <= count + 1'b1;
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/afpm_div_iter.sv
// Iterative approximate float32 divider with valid/ready handshakes.
// Handles specials, exponent and packing around the significand loop.
module afpm_div_iter
    import afpm_pkg::*;
#(
    parameter int E = 10,
    parameter int A = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] fp_dividend,
    input  logic [31:0] fp_divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] fp_quotient
);

    localparam int W = E + A;

    div_state_t        state, state_n;
    float32_t          fa, fb;
    fp_class_t         ca, cb;
    logic              accept;
    logic              start;
    logic              s;
    logic              spec_hit;
    logic [31:0]       spec_val;
    logic              sign_r;
    logic signed [9:0] exp_r;
    logic              spec_r;
    logic [31:0]       spec_val_r;
    logic              done;
    logic [W:0]        q;
    logic signed [9:0] e_adj;
    logic [22:0]       frac;
    logic [31:0]       packed_q;

    // Keep the top W bits; jam the first dropped bit into the LSB.
    function automatic logic [W-1:0] keep_sig(float32_t f);
        logic [23:0]  m;
        logic [W-1:0] k;
        m    = {1'b1, f.frac};
        k    = m[23 -: W];
        k[0] = k[0] | m[23-W];
        return k;
    endfunction

    assign fa = fp_dividend;
    assign fb = fp_divisor;

    always_comb begin
        ca       = fp_classify(fa);
        cb       = fp_classify(fb);
        s        = fa.sign ^ fb.sign;
        spec_hit = 1'b1;
        spec_val = {s, 31'd0};
        if (ca.is_nan || cb.is_nan || (ca.is_zero && cb.is_zero) ||
            (ca.is_inf && cb.is_inf))
            spec_val = FP_NAN;
        else if (ca.is_inf || cb.is_zero)
            spec_val = {s, FP_INF_EXP, 23'd0};
        else if (ca.is_zero || cb.is_inf)
            spec_val = {s, 31'd0};
        else
            spec_hit = 1'b0;
    end

    assign accept = in_valid && in_ready;
    assign start  = accept && !spec_hit;

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) state_n = spec_hit ? DONE : CALC;
            end
            CALC: if (done) state_n = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sign_r     <= 1'b0;
            exp_r      <= '0;
            spec_r     <= 1'b0;
            spec_val_r <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                sign_r     <= s;
                exp_r      <= 10'({2'b00, fa.exp}) - 10'({2'b00, fb.exp})
                              + 10'(EXP_BIAS);
                spec_r     <= spec_hit;
                spec_val_r <= spec_val;
            end
        end
    end

    afpm_sig_divider #(.W(W)) u_sig_div (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_sig    (keep_sig(fa)),
        .b_sig    (keep_sig(fb)),
        .done     (done),
        .quotient (q)
    );

    // Quotient below 1.0 costs one exponent step; result truncates.
    always_comb begin
        e_adj = exp_r - {9'd0, ~q[W]};
        if (q[W])
            frac = 23'(q[W-1:0]) << (23 - W);
        else
            frac = 23'(q[W-2:0]) << (24 - W);
        if (e_adj <= 10'sd0)
            packed_q = {sign_r, 31'd0};
        else if (e_adj >= 10'sd255)
            packed_q = {sign_r, FP_INF_EXP, 23'd0};
        else
            packed_q = {sign_r, e_adj[7:0], frac};
        fp_quotient = '0;
        if (state == DONE)
            fp_quotient = spec_r ? spec_val_r : packed_q;
    end

endmodule

// File: tb/tb_afpm_div_iter.sv
// Self-checking bench for afpm_div_iter: directed cases plus
// randomized back-to-back traffic against an arithmetic reference model.
module tb_afpm_div_iter;

    localparam int W = 16;
    localparam int Q = W + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] fp_dividend = '0;
    logic [31:0] fp_divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] fp_quotient;

    int n_cmp = 0;
    int n_err = 0;

    afpm_div_iter dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .fp_dividend (fp_dividend),
        .fp_divisor  (fp_divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .fp_quotient (fp_quotient)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic longint keep(input logic [31:0] x);
        longint m, k;
        m = 64'h80_0000 + longint'(x[22:0]);
        k = m / 256;
        if ((m / 128) % 2 == 1) k = k | 1;
        return k;
    endfunction

    // Reference: specials by rule, otherwise integer division of kept sigs.
    function automatic logic [31:0] ref_div(input logic [31:0] a,
                                            input logic [31:0] b);
        int     ea, eb, e, adj;
        bit     s, za, zb, ia, ib, na, nb;
        longint qv, f;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 0);
        ib = (eb == 255) && (b[22:0] == 0);
        na = (ea == 255) && (a[22:0] != 0);
        nb = (eb == 255) && (b[22:0] != 0);
        if (na || nb || (za && zb) || (ia && ib)) return 32'h7FFF_FFFF;
        if (ia || zb) return {s, 8'hFF, 23'd0};
        if (za || ib) return {s, 31'd0};
        qv  = (keep(a) * 65536) / keep(b);
        adj = (qv >= 65536) ? 0 : 1;
        e   = ea - eb + 127 - adj;
        if (e <= 0) return {s, 31'd0};
        if (e >= 255) return {s, 8'hFF, 23'd0};
        f = (qv * ((adj == 1) ? 256 : 128)) % 64'h80_0000;
        return {s, e[7:0], f[22:0]};
    endfunction

    task automatic do_op(input string tag, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input int exp_lat, input int hold);
        int lat;
        @(negedge clk);
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        fp_dividend = a;
        fp_divisor  = b;
        in_valid    = 1'b1;
        out_ready   = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(posedge clk);
            #1 lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check(tag, fp_quotient, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_q", fp_quotient, exp);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, "_back_idle"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [31:0] expq[$];
        int idx, got, cyc, last;
        bit seen;

        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_q", fp_quotient, 32'd0);

        do_op("six_div_two", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, Q, 0);
        do_op("one_div_three", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AA00, Q, 0);
        do_op("zero_zero", 32'h0, 32'h0, 32'h7FFF_FFFF, 0, 0);
        do_op("neg_div_zero", 32'hBF80_0000, 32'h0, 32'hFF80_0000, 0, 0);
        do_op("inf_inf", 32'h7F80_0000, 32'h7F80_0000, 32'h7FFF_FFFF, 0, 0);
        do_op("zero_div_x", 32'h0, 32'h4000_0000, 32'h0, 0, 0);
        do_op("overflow", 32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, Q, 0);
        do_op("underflow", 32'h0080_0000, 32'h7F00_0000, 32'h0, Q, 0);
        do_op("subnormal", 32'h0000_0001, 32'h3F80_0000, 32'h0, 0, 0);
        do_op("backpressure", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, Q, 5);

        @(negedge clk);
        fp_dividend = 32'h40C0_0000;
        fp_divisor  = 32'h4000_0000;
        in_valid    = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk) rst = 1'b0;
        seen = 1'b0;
        repeat (Q + 4) begin
            @(posedge clk);
            #1 if (out_valid) seen = 1'b1;
        end
        check("abort_no_spurious", 32'(seen), 32'd0);
        do_op("after_abort", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, Q, 0);

        idx  = 0;
        got  = 0;
        cyc  = 0;
        last = -1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        while (got < 20 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                if (expq.size() > 0) check("b2b_q", fp_quotient, expq.pop_front());
                else check("b2b_extra", 32'(out_valid), 32'd0);
                if (last >= 0) check("b2b_gap", 32'(cyc - last), 32'(Q + 2));
                last = cyc;
                got++;
            end
            if (in_ready) begin
                if (idx < 20) begin
                    ra = {1'($urandom), 8'($urandom_range(190, 64)), 23'($urandom)};
                    rb = {1'($urandom), 8'($urandom_range(190, 64)), 23'($urandom)};
                    fp_dividend = ra;
                    fp_divisor  = rb;
                    expq.push_back(ref_div(ra, rb));
                    idx++;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        check("b2b_count", 32'(got), 32'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
